neighbor_edge_gen: RTL

//  Downstream consumer of get_neighbor_pixels. It accepts one event at a time:

---
 rtl/neighbor_edge_gen.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/neighbor_edge_gen.sv
// rtl/neighbor_edge_gen.sv - scans a 5x5 pixel->node window and emits one edge per recent neighbour node
// The new event is written into the table at its centre pixel only after every neighbour read.
module neighbor_edge_gen #(
  parameter int NUM_NB    = 25,
  parameter int NUM_PIX   = 12000,
  parameter int IDX_W     = $clog2(NUM_PIX) + 2,
  parameter int NODE_W    = 14,
  parameter int TS_W      = 16,
  parameter int TS_WINDOW = 1000,
  parameter int ADDR_W    = $clog2(NUM_PIX),
  parameter int ENT_W     = 1 + NODE_W + TS_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NODE_W-1:0]       in_node_id,
  input  logic [TS_W-1:0]         in_ts,
  input  logic signed [IDX_W-1:0] in_nb [NUM_NB],
  output logic                    tbl_rd_en,
  output logic [ADDR_W-1:0]       tbl_rd_addr,
  input  logic [ENT_W-1:0]        tbl_rd_data,
  output logic                    tbl_wr_en,
  output logic [ADDR_W-1:0]       tbl_wr_addr,
  output logic [ENT_W-1:0]        tbl_wr_data,
  output logic                    edge_valid,
  input  logic                    edge_ready,
  output logic [NODE_W-1:0]       edge_src,
  output logic [NODE_W-1:0]       edge_dst,
  output logic                    done,
  output logic [4:0]              edge_cnt
);

  localparam int K_W    = $clog2(NUM_NB);
  localparam int CENTRE = (NUM_NB - 1) / 2;
  localparam logic [IDX_W-1:0] NUM_PIX_U = IDX_W'(NUM_PIX);
  localparam logic [TS_W-1:0]  WINDOW_U  = TS_W'(TS_WINDOW);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(NUM_NB - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CMP  = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [NODE_W-1:0]       id_q;
  logic [TS_W-1:0]         ts_q;
  logic signed [IDX_W-1:0] nb_q [NUM_NB];
  logic [NODE_W-1:0]       src_q, src_d;
  logic [NODE_W-1:0]       dst_q, dst_d;

  logic signed [IDX_W-1:0] cur_nb;
  logic signed [IDX_W-1:0] ctr_nb;
  logic                    cur_ok, ctr_ok, last_k, hit;
  logic                    rd_vld;
  logic [NODE_W-1:0]       rd_node;
  logic [TS_W-1:0]         rd_ts, age;
  logic                    accept;

  function automatic logic idx_ok(input logic signed [IDX_W-1:0] v);
    return !v[IDX_W-1] && ($unsigned(v) < NUM_PIX_U);
  endfunction

  assign cur_nb  = nb_q[k_q];
  assign ctr_nb  = nb_q[CENTRE];
  assign cur_ok  = idx_ok(cur_nb);
  assign ctr_ok  = idx_ok(ctr_nb);
  assign last_k  = (k_q == K_LAST);
  assign accept  = (state_q == S_IDLE) && in_valid;

  assign rd_vld  = tbl_rd_data[ENT_W-1];
  assign rd_node = tbl_rd_data[NODE_W+TS_W-1:TS_W];
  assign rd_ts   = tbl_rd_data[TS_W-1:0];
  // Unsigned wrap subtraction keeps ages correct across timestamp rollover.
  assign age     = ts_q - rd_ts;
  assign hit     = rd_vld && (age <= WINDOW_U);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    dst_d     = dst_q;
    tbl_rd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RD;
          k_d     = '0;
          cnt_d   = '0;
        end
      end
      S_RD: begin
        if (cur_ok) begin
          tbl_rd_en = 1'b1;
          state_d   = S_CMP;
        end else if (last_k) begin
          state_d = S_WR;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_CMP: begin
        if (hit) begin
          src_d   = rd_node;
          dst_d   = id_q;
          cnt_d   = cnt_q + 5'd1;
          state_d = S_EMIT;
        end else if (last_k) begin
          state_d = S_WR;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_EMIT: begin
        if (edge_ready) begin
          if (last_k) begin
            state_d = S_WR;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_WR:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      ts_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      for (int i = 0; i < NUM_NB; i++) nb_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      if (accept) begin
        id_q <= in_node_id;
        ts_q <= in_ts;
        nb_q <= in_nb;
      end
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign tbl_rd_addr = tbl_rd_en ? cur_nb[ADDR_W-1:0] : '0;
  assign edge_valid  = (state_q == S_EMIT);
  assign edge_src    = src_q;
  assign edge_dst    = dst_q;
  assign done        = (state_q == S_WR);
  assign edge_cnt    = done ? cnt_q : '0;
  // An out-of-range centre still completes the event but must not corrupt the table.
  assign tbl_wr_en   = done && ctr_ok;
  assign tbl_wr_addr = tbl_wr_en ? ctr_nb[ADDR_W-1:0] : '0;
  assign tbl_wr_data = tbl_wr_en ? {1'b1, id_q, ts_q} : '0;

endmodule
